// File: rtl/mem_port_arbiter.sv
// Shares one req/gnt/rvalid memory port between instruction fetch and the LSU.
// LSU wins ties unless IF has already waited through STARVE_MAX LSU grants.
module mem_port_arbiter #(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  // Instruction fetch
  input  logic            if_req_i,
  input  logic [AW-1:0]   if_addr_i,
  output logic            if_gnt_o,
  output logic            if_rvalid_o,
  output logic [DW-1:0]   if_rdata_o,
  // Load/store unit
  input  logic            lsu_req_i,
  input  logic            lsu_we_i,
  input  logic [DW/8-1:0] lsu_be_i,
  input  logic [AW-1:0]   lsu_addr_i,
  input  logic [DW-1:0]   lsu_wdata_i,
  output logic            lsu_gnt_o,
  output logic            lsu_rvalid_o,
  output logic [DW-1:0]   lsu_rdata_o,
  // Memory bus
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [DW/8-1:0] mem_be_o,
  output logic [AW-1:0]   mem_addr_o,
  output logic [DW-1:0]   mem_wdata_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [DW-1:0]   mem_rdata_i,
  // Pipeline control
  output logic            fetch_wait_o,
  output logic            lsu_wait_o,
  output logic            proto_err_o
);

  localparam int unsigned BW = DW / 8;
  localparam int unsigned CW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e          state_q, state_d;
  logic            owner_if_q, owner_if_d;
  logic            we_q, we_d;
  logic [BW-1:0]   be_q, be_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [CW-1:0]   starve_q, starve_d;
  logic            err_q, err_d;

  logic            arb_en, starved, win_if, win_lsu;
  logic            if_gnt, lsu_gnt, if_rvalid, lsu_rvalid;

  assign starved = (starve_q == CW'(STARVE_MAX));
  assign win_if  = if_req_i & (~lsu_req_i | starved);
  assign win_lsu = lsu_req_i & ~win_if;

  always_comb begin
    state_d    = state_q;
    owner_if_d = owner_if_q;
    we_d       = we_q;
    be_d       = be_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    arb_en     = 1'b0;
    if_gnt     = 1'b0;
    lsu_gnt    = 1'b0;
    if_rvalid  = 1'b0;
    lsu_rvalid = 1'b0;

    unique case (state_q)
      StIdle:  arb_en = 1'b1;
      StIssue: begin
        if (mem_gnt_i) begin
          if_gnt  = owner_if_q;
          lsu_gnt = ~owner_if_q;
          state_d = StResp;
        end
      end
      StResp: begin
        // Re-arbitrate on the response cycle so the bus sees no idle bubble.
        if (mem_rvalid_i) begin
          if_rvalid  = owner_if_q;
          lsu_rvalid = ~owner_if_q;
          arb_en     = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (arb_en) begin
      if (win_if || win_lsu) begin
        state_d    = StIssue;
        owner_if_d = win_if;
        addr_d     = win_if ? if_addr_i : lsu_addr_i;
        we_d       = win_lsu & lsu_we_i;
        be_d       = win_if ? {BW{1'b1}} : lsu_be_i;
        wdata_d    = win_if ? '0 : lsu_wdata_i;
      end else begin
        state_d = StIdle;
      end
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!if_req_i || if_gnt) begin
      starve_d = '0;
    end else if (lsu_gnt && !starved) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // Stray bus events are flagged and otherwise dropped.
  assign err_d = err_q | (mem_rvalid_i & (state_q != StResp))
                       | (mem_gnt_i & (state_q != StIssue));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      owner_if_q <= 1'b0;
      we_q       <= 1'b0;
      be_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      starve_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_if_q <= owner_if_d;
      we_q       <= we_d;
      be_q       <= be_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      starve_q   <= starve_d;
      err_q      <= err_d;
    end
  end

  // Outputs are forced low while reset is held, even before the state register clears.
  assign mem_req_o    = ~rst & (state_q == StIssue);
  assign mem_we_o     = ~rst & we_q;
  assign mem_be_o     = rst ? '0 : be_q;
  assign mem_addr_o   = rst ? '0 : addr_q;
  assign mem_wdata_o  = rst ? '0 : wdata_q;

  assign if_gnt_o     = ~rst & if_gnt;
  assign lsu_gnt_o    = ~rst & lsu_gnt;
  assign if_rvalid_o  = ~rst & if_rvalid;
  assign lsu_rvalid_o = ~rst & lsu_rvalid;
  assign if_rdata_o   = if_rvalid_o ? mem_rdata_i : '0;
  assign lsu_rdata_o  = lsu_rvalid_o ? mem_rdata_i : '0;
  assign proto_err_o  = ~rst & err_q;

  assign fetch_wait_o = if_req_i & ~if_gnt_o;
  assign lsu_wait_o   = lsu_req_i & ~lsu_gnt_o;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SM = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [31:0]   if_addr;
  logic          if_gnt, if_rvalid;
  logic [31:0]   if_rdata;
  logic          lsu_req, lsu_we;
  logic [3:0]    lsu_be;
  logic [31:0]   lsu_addr, lsu_wdata;
  logic          lsu_gnt, lsu_rvalid;
  logic [31:0]   lsu_rdata;
  logic          mem_req, mem_we;
  logic [3:0]    mem_be;
  logic [31:0]   mem_addr, mem_wdata;
  logic          mem_gnt, mem_rvalid;
  logic [31:0]   mem_rdata;
  logic          fetch_wait, lsu_wait, proto_err;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SM)) dut (
    .clk          (clk),
    .rst          (rst),
    .if_req_i     (if_req),
    .if_addr_i    (if_addr),
    .if_gnt_o     (if_gnt),
    .if_rvalid_o  (if_rvalid),
    .if_rdata_o   (if_rdata),
    .lsu_req_i    (lsu_req),
    .lsu_we_i     (lsu_we),
    .lsu_be_i     (lsu_be),
    .lsu_addr_i   (lsu_addr),
    .lsu_wdata_i  (lsu_wdata),
    .lsu_gnt_o    (lsu_gnt),
    .lsu_rvalid_o (lsu_rvalid),
    .lsu_rdata_o  (lsu_rdata),
    .mem_req_o    (mem_req),
    .mem_we_o     (mem_we),
    .mem_be_o     (mem_be),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_gnt_i    (mem_gnt),
    .mem_rvalid_i (mem_rvalid),
    .mem_rdata_i  (mem_rdata),
    .fetch_wait_o (fetch_wait),
    .lsu_wait_o   (lsu_wait),
    .proto_err_o  (proto_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: one outstanding transaction record plus the IF starvation tally.
  bit          t_open;      // a transaction has been chosen and not yet answered
  bit          t_accepted;  // the bus has granted it
  bit          t_is_if;
  bit          t_we;
  logic [3:0]  t_be;
  logic [31:0] t_addr, t_wdata;
  bit          m_err;
  int          lsu_streak;

  bit          e_if_gnt, e_lsu_gnt;
  int          rv_dly;
  int          n_if_gnt_seen, n_lsu_gnt_seen, n_lsu_rv_seen;
  logic [31:0] last_if_rdata;
  string       glog;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  // Inputs for this cycle are already applied; compare at negedge, advance model at posedge.
  task automatic cycle();
    bit waiting_gnt, waiting_rsp, e_if_rv, e_lsu_rv, pick_if, pick_lsu, choose;
    @(negedge clk);
    waiting_gnt = t_open && !t_accepted;
    waiting_rsp = t_open && t_accepted;
    e_if_gnt  = !rst && waiting_gnt && mem_gnt && t_is_if;
    e_lsu_gnt = !rst && waiting_gnt && mem_gnt && !t_is_if;
    e_if_rv   = !rst && waiting_rsp && mem_rvalid && t_is_if;
    e_lsu_rv  = !rst && waiting_rsp && mem_rvalid && !t_is_if;

    check_eq("mem_req", mem_req, !rst && waiting_gnt);
    if (rst) begin
      check_eq("rst_mem_we", mem_we, 0);
      check_eq("rst_mem_be", mem_be, 0);
      check_eq("rst_mem_addr", mem_addr, 0);
      check_eq("rst_mem_wdata", mem_wdata, 0);
    end else if (waiting_gnt) begin
      check_eq("mem_we", mem_we, t_we);
      check_eq("mem_be", mem_be, t_be);
      check_eq("mem_addr", mem_addr, t_addr);
      check_eq("mem_wdata", mem_wdata, t_wdata);
    end
    check_eq("if_gnt", if_gnt, e_if_gnt);
    check_eq("lsu_gnt", lsu_gnt, e_lsu_gnt);
    check_eq("if_rvalid", if_rvalid, e_if_rv);
    check_eq("lsu_rvalid", lsu_rvalid, e_lsu_rv);
    check_eq("if_rdata", if_rdata, e_if_rv ? mem_rdata : 32'h0);
    check_eq("lsu_rdata", lsu_rdata, e_lsu_rv ? mem_rdata : 32'h0);
    check_eq("fetch_wait", fetch_wait, if_req && !e_if_gnt);
    check_eq("lsu_wait", lsu_wait, lsu_req && !e_lsu_gnt);
    check_eq("proto_err", proto_err, !rst && m_err);

    if (if_gnt) begin n_if_gnt_seen++; glog = {glog, "I"}; end
    if (lsu_gnt) begin n_lsu_gnt_seen++; glog = {glog, "L"}; end
    if (lsu_rvalid) n_lsu_rv_seen++;
    if (if_rvalid) last_if_rdata = if_rdata;

    @(posedge clk);
    if (rst) begin
      t_open = 0; t_accepted = 0; m_err = 0; lsu_streak = 0;
    end else begin
      if ((mem_rvalid && !waiting_rsp) || (mem_gnt && !waiting_gnt)) m_err = 1;
      choose   = !t_open || (waiting_rsp && mem_rvalid);
      pick_if  = if_req && (!lsu_req || lsu_streak == SM);
      pick_lsu = lsu_req && !pick_if;
      if (waiting_gnt && mem_gnt) t_accepted = 1;
      if (!if_req || e_if_gnt) lsu_streak = 0;
      else if (e_lsu_gnt && lsu_streak < SM) lsu_streak++;
      if (choose) begin
        t_open = pick_if || pick_lsu;
        t_accepted = 0;
        if (pick_if) begin
          t_is_if = 1; t_addr = if_addr; t_we = 0; t_be = 4'hF; t_wdata = 0;
        end else if (pick_lsu) begin
          t_is_if = 0; t_addr = lsu_addr; t_we = lsu_we; t_be = lsu_be; t_wdata = lsu_wdata;
        end
      end
    end
    #1;
  endtask

  task automatic mem_fast();
    mem_gnt    = t_open && !t_accepted;
    mem_rvalid = t_open && t_accepted;
    mem_rdata  = $urandom;
  endtask

  task automatic mem_quiet();
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
  endtask

  task automatic drop_granted();
    if (e_if_gnt) if_req = 0;
    if (e_lsu_gnt) lsu_req = 0;
  endtask

  task automatic drain();
    if_req = 0; lsu_req = 0;
    for (int k = 0; k < 6; k++) begin mem_fast(); cycle(); end
    mem_quiet();
  endtask

  initial begin
    int g0, rv0;
    rst = 1; if_req = 1; if_addr = 32'h44; lsu_req = 0; lsu_we = 0; lsu_be = 0;
    lsu_addr = 0; lsu_wdata = 0; mem_quiet();
    t_open = 0; t_accepted = 0; m_err = 0; lsu_streak = 0; glog = "";
    @(posedge clk); #1;
    // Reset with IF requesting: outputs low, fetch_wait follows the request.
    cycle(); cycle();
    rst = 0; if_req = 0;
    cycle();

    // Single fetch: gnt on the 2nd issue cycle, response 3 cycles later.
    g0 = n_if_gnt_seen; rv0 = n_lsu_rv_seen;
    if_addr = 32'h100;
    for (int k = 0; k < 8; k++) begin
      if_req = (k <= 2); mem_gnt = (k == 2); mem_rvalid = (k == 5);
      mem_rdata = 32'hDEAD_BEEF;
      cycle();
    end
    mem_quiet();
    check_eq("t1_if_gnt_count", n_if_gnt_seen - g0, 1);
    check_eq("t1_if_rdata", last_if_rdata, 32'hDEAD_BEEF);
    check_eq("t1_lsu_rvalid_count", n_lsu_rv_seen - rv0, 0);

    // Simultaneous requests: LSU store first, then fetch.
    glog = "";
    if_req = 1; if_addr = 32'h300;
    lsu_req = 1; lsu_we = 1; lsu_addr = 32'h200; lsu_wdata = 32'h55; lsu_be = 4'hF;
    for (int k = 0; k < 8; k++) begin mem_fast(); cycle(); drop_granted(); end
    check_eq("t2_order_LI", glog == "LI", 1);
    drain();

    // Starvation: both held continuously.
    glog = "";
    if_req = 1; lsu_req = 1; lsu_we = 0;
    for (int k = 0; k < 26; k++) begin mem_fast(); cycle(); end
    check_eq("t3_order", (glog.len() >= 10) && (glog.substr(0, 9) == "LLLLILLLLI"), 1);
    drain();

    // Back-to-back LSU: a new request follows each grant immediately.
    g0 = n_lsu_gnt_seen;
    lsu_req = 1;
    for (int k = 0; k < 10; k++) begin
      mem_fast(); cycle();
      if (e_lsu_gnt) begin lsu_addr = $urandom & 32'hFFFF_FFFC; lsu_wdata = $urandom; end
    end
    check_eq("t4_lsu_gnt_count", n_lsu_gnt_seen - g0, 5);
    drain();

    // Reset while waiting for the response, then a stray rvalid.
    rv0 = n_lsu_rv_seen;
    lsu_req = 1; lsu_we = 0; lsu_addr = 32'h40;
    mem_fast(); cycle();
    mem_fast(); cycle(); drop_granted();
    rst = 1; mem_quiet(); cycle();
    rst = 0; mem_rvalid = 1; mem_rdata = 32'h1234_5678; cycle();
    mem_quiet();
    check_eq("t5_proto_err", proto_err, 1);
    cycle();
    check_eq("t5_lsu_rvalid_count", n_lsu_rv_seen - rv0, 0);

    // Spurious grant while idle.
    rst = 1; cycle(); rst = 0;
    g0 = n_if_gnt_seen + n_lsu_gnt_seen;
    check_eq("t6_err_cleared", proto_err, 0);
    mem_gnt = 1; cycle(); mem_quiet();
    check_eq("t6_proto_err", proto_err, 1);
    cycle();
    check_eq("t6_no_gnt", n_if_gnt_seen + n_lsu_gnt_seen - g0, 0);

    // Randomized traffic with random bus latency and occasional resets.
    rst = 1; cycle(); rst = 0;
    rv_dly = 0;
    for (int k = 0; k < 3000; k++) begin
      if (!if_req || e_if_gnt) begin
        if_req = ($urandom % 2) == 0; if_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!lsu_req || e_lsu_gnt) begin
        lsu_req = ($urandom % 4) != 0; lsu_we = $urandom % 2; lsu_be = $urandom;
        lsu_addr = $urandom & 32'hFFFF_FFFC; lsu_wdata = $urandom;
      end
      rst = ($urandom % 250) == 0;
      mem_gnt = 0; mem_rvalid = 0; mem_rdata = $urandom;
      if (t_open && !t_accepted) begin
        mem_gnt = ($urandom % 3) != 0;
        if (mem_gnt) rv_dly = $urandom % 3;
      end else if (t_open && t_accepted) begin
        if (rv_dly == 0) mem_rvalid = 1;
        else rv_dly--;
      end
      cycle();
    end
    rst = 0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
